// File: rtl/apple_gen_pkg.sv
// -----------------------------------------------------------------------------
// apple_gen_pkg
// Shared snake-game definitions: playfield size, coordinate widths matching
// the drawing stage, LFSR seed/taps and the apple generator state encoding.
// -----------------------------------------------------------------------------
package apple_gen_pkg;

  localparam int GRID_COLS = 64;
  localparam int GRID_ROWS = 48;

  // Coordinate widths are fixed by the apple drawing stage.
  localparam int X_W = 7;
  localparam int Y_W = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    QUERY = 3'd2,
    SCAN  = 3'd3,
    FULL  = 3'd4
  } state_t;

endpackage

// File: rtl/apple_gen_if.sv
// -----------------------------------------------------------------------------
// apple_gen_if
// Occupancy query handshake between the apple generator (master) and the
// snake-body store (slave).
//   query_req  : request, held high until occ_valid
//   query_x/y  : cell being queried, stable while query_req is high
//   occ_valid  : response strobe
//   occ_hit    : cell occupied, meaningful only with occ_valid
// -----------------------------------------------------------------------------
interface apple_gen_if;
  import apple_gen_pkg::*;

  logic           query_req;
  logic [X_W-1:0] query_x;
  logic [Y_W-1:0] query_y;
  logic           occ_valid;
  logic           occ_hit;

  modport master (
    output query_req, query_x, query_y,
    input  occ_valid, occ_hit
  );

  modport slave (
    input  query_req, query_x, query_y,
    output occ_valid, occ_hit
  );

endinterface

// File: rtl/apple_gen_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR, right-shifting, free running on every pclk edge.
// Ports: pclk (clock), rst_n (async active-low reset to seed), state (value).
// -----------------------------------------------------------------------------
module lfsr16
  import apple_gen_pkg::*;
(
  input  logic        pclk,
  input  logic        rst_n,
  output logic [15:0] state
);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else if (state[0]) begin
      state <= (state >> 1) ^ LFSR_TAPS;
    end else begin
      state <= state >> 1;
    end
  end

endmodule

// File: rtl/apple_gen.sv
// -----------------------------------------------------------------------------
// apple_gen
// Places a new apple on a free playfield cell after each eaten pulse. Random
// candidates come from an LFSR and are checked against the snake body via the
// occupancy query bus; after MAX_TRIES rejections a raster scan from (0,0)
// guarantees termination, and a fully occupied board latches board_full.
// Ports:
//   pclk, rst_n        clock, asynchronous active-low reset
//   eaten              one-cycle pulse, snake head entered the apple cell
//   bus (master)       occupancy query handshake
//   apple_x / apple_y  current apple cell (registered)
//   apple_valid        apple_x/y hold a placed, free cell
//   busy               search in progress
//   board_full         sticky, no free cell exists
// -----------------------------------------------------------------------------
module apple_gen
  import apple_gen_pkg::*;
#(
  parameter int GRID_COLS = apple_gen_pkg::GRID_COLS,
  parameter int GRID_ROWS = apple_gen_pkg::GRID_ROWS,
  parameter int MAX_TRIES = 255,
  parameter int INIT_X    = 40,
  parameter int INIT_Y    = 24
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic           eaten,
  apple_gen_if.master    bus,
  output logic [X_W-1:0] apple_x,
  output logic [Y_W-1:0] apple_y,
  output logic           apple_valid,
  output logic           busy,
  output logic           board_full
);

  localparam int             TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [X_W-1:0] COLS_M1  = X_W'(GRID_COLS - 1);
  localparam logic [Y_W-1:0] ROWS_M1  = Y_W'(GRID_ROWS - 1);

  state_t           state;
  logic [TRY_W-1:0] tries;
  logic [15:0]      lfsr;
  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  logic             cand_ok;
  logic             last_try;
  logic             resp;
  logic             last_cell;

  lfsr16 u_lfsr (
    .pclk  (pclk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  assign cand_x    = lfsr[6:0];
  assign cand_y    = lfsr[12:7];
  assign cand_ok   = (cand_x <= COLS_M1) && (cand_y <= ROWS_M1);
  assign last_try  = (tries == TRY_LAST);
  // A strobe without an outstanding request is stale and must be ignored.
  assign resp      = bus.occ_valid && bus.query_req;
  assign last_cell = (bus.query_x == COLS_M1) && (bus.query_y == ROWS_M1);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tries         <= '0;
      apple_x       <= X_W'(INIT_X);
      apple_y       <= Y_W'(INIT_Y);
      apple_valid   <= 1'b1;
      busy          <= 1'b0;
      board_full    <= 1'b0;
      bus.query_req <= 1'b0;
      bus.query_x   <= '0;
      bus.query_y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eaten) begin
            state       <= DRAW;
            apple_valid <= 1'b0;
            busy        <= 1'b1;
            tries       <= '0;
          end
        end

        DRAW: begin
          if (cand_ok) begin
            bus.query_x   <= cand_x;
            bus.query_y   <= cand_y;
            bus.query_req <= 1'b1;
            state         <= QUERY;
          end else if (last_try) begin
            bus.query_x <= '0;
            bus.query_y <= '0;
            state       <= SCAN;
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end

        QUERY: begin
          if (resp) begin
            // query_req drops on every response so each new query is a fresh
            // rising edge for the responder.
            bus.query_req <= 1'b0;
            if (!bus.occ_hit) begin
              apple_x     <= bus.query_x;
              apple_y     <= bus.query_y;
              apple_valid <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else if (last_try) begin
              bus.query_x <= '0;
              bus.query_y <= '0;
              state       <= SCAN;
            end else begin
              tries <= tries + TRY_W'(1);
              state <= DRAW;
            end
          end
        end

        SCAN: begin
          if (!bus.query_req) begin
            bus.query_req <= 1'b1;
          end else if (resp) begin
            bus.query_req <= 1'b0;
            if (!bus.occ_hit) begin
              apple_x     <= bus.query_x;
              apple_y     <= bus.query_y;
              apple_valid <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else if (last_cell) begin
              board_full <= 1'b1;
              busy       <= 1'b0;
              state      <= FULL;
            end else if (bus.query_x == COLS_M1) begin
              bus.query_x <= '0;
              bus.query_y <= bus.query_y + Y_W'(1);
            end else begin
              bus.query_x <= bus.query_x + X_W'(1);
            end
          end
        end

        FULL: begin
          // Terminal until reset.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_gen.sv
// -----------------------------------------------------------------------------
// tb_apple_gen
// Directed bench for apple_gen with a behavioural occupancy responder.
// -----------------------------------------------------------------------------
module tb_apple_gen;
  import apple_gen_pkg::*;

  logic       pclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       eaten = 1'b0;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_valid;
  logic       busy;
  logic       board_full;

  apple_gen_if bus ();

  apple_gen dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .eaten       (eaten),
    .bus         (bus),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .apple_valid (apple_valid),
    .busy        (busy),
    .board_full  (board_full)
  );

  always #5 pclk = ~pclk;

  // Responder modes: 0 never hit, 1 hit first 3 queries of a test,
  // 2 hit everything but (5,2), 3 always hit.
  int         mode       = 0;
  int         resp_lat   = 1;
  bit         resp_en    = 1'b1;
  bit         force_late = 1'b0;
  int         nq         = 0;
  int         nq_base    = 0;
  int         wait_cnt   = 0;
  logic [6:0] last_qx    = '0;
  logic [5:0] last_qy    = '0;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic hit_of(input logic [6:0] x, input logic [5:0] y, input int n);
    case (mode)
      0:       return 1'b0;
      1:       return (n - nq_base) < 3;
      2:       return !(x == 7'd5 && y == 6'd2);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge pclk) begin
    if (!rst_n) begin
      bus.occ_valid <= 1'b0;
      bus.occ_hit   <= 1'b0;
      wait_cnt      <= 0;
    end else begin
      bus.occ_valid <= 1'b0;
      if (force_late) begin
        bus.occ_valid <= 1'b1;
        bus.occ_hit   <= 1'b0;
      end else if (!bus.query_req || bus.occ_valid) begin
        wait_cnt <= 0;
      end else if (resp_en) begin
        if (wait_cnt + 1 >= resp_lat) begin
          bus.occ_valid <= 1'b1;
          bus.occ_hit   <= hit_of(bus.query_x, bus.query_y, nq);
          nq            <= nq + 1;
          last_qx       <= bus.query_x;
          last_qy       <= bus.query_y;
          wait_cnt      <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pulse eaten and wait for apple_valid. Sample index 1 is the first negedge
  // after the edge that captured eaten.
  task automatic run_search(input int budget, output int t_req, output int t_val);
    t_req = -1;
    t_val = -1;
    @(negedge pclk) eaten = 1'b1;
    @(negedge pclk) eaten = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      if (i > 1) @(negedge pclk);
      if (t_req < 0 && bus.query_req) t_req = i;
      if (apple_valid) begin
        t_val = i;
        break;
      end
    end
  endtask

  initial begin
    int         t_req;
    int         t_val;
    int         t_full;
    logic [6:0] hold_qx;
    logic [5:0] hold_qy;

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_req_async", 32'(bus.query_req), 32'd0);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("rst_x", 32'(apple_x), 32'd40);
    chk("rst_y", 32'(apple_y), 32'd24);
    chk("rst_valid", 32'(apple_valid), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(bus.query_req), 32'd0);
    chk("rst_full", 32'(board_full), 32'd0);

    // Free board, 1-cycle responder, several placements
    mode = 0;
    for (int k = 0; k < 3; k++) begin
      run_search(100, t_req, t_val);
      chk("free_done", 32'(t_val > 0), 32'd1);
      chk("free_lat", 32'(t_val - t_req), 32'd2);
      chk("free_x_range", 32'(apple_x < 7'd64), 32'd1);
      chk("free_y_range", 32'(apple_y < 6'd48), 32'd1);
      chk("free_x_eq_q", 32'(apple_x), 32'(last_qx));
      chk("free_y_eq_q", 32'(apple_y), 32'(last_qy));
      chk("free_req_low", 32'(bus.query_req), 32'd0);
      chk("free_busy_low", 32'(busy), 32'd0);
      repeat (k + 2) @(negedge pclk);
    end

    // First three queries occupied, fourth accepted
    mode    = 1;
    nq_base = nq;
    run_search(500, t_req, t_val);
    chk("hit3_done", 32'(t_val > 0), 32'd1);
    chk("hit3_nq", 32'(nq - nq_base), 32'd4);
    chk("hit3_x", 32'(apple_x), 32'(last_qx));
    chk("hit3_y", 32'(apple_y), 32'(last_qy));

    // Only (5,2) free: found by the fallback scan
    mode = 2;
    run_search(6000, t_req, t_val);
    chk("scan_done", 32'(t_val > 0), 32'd1);
    chk("scan_x", 32'(apple_x), 32'd5);
    chk("scan_y", 32'(apple_y), 32'd2);
    chk("scan_full", 32'(board_full), 32'd0);

    // Fully occupied board
    mode   = 3;
    t_full = -1;
    @(negedge pclk) eaten = 1'b1;
    @(negedge pclk) eaten = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (board_full) begin
        t_full = i;
        break;
      end
      @(negedge pclk);
    end
    chk("full_set", 32'(t_full >= 0), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_valid", 32'(apple_valid), 32'd0);
    chk("full_req", 32'(bus.query_req), 32'd0);
    chk("full_lastq_x", 32'(last_qx), 32'd63);
    chk("full_lastq_y", 32'(last_qy), 32'd47);
    @(negedge pclk) eaten = 1'b1;
    @(negedge pclk) eaten = 1'b0;
    repeat (4) @(negedge pclk);
    chk("full_eaten_busy", 32'(busy), 32'd0);
    chk("full_eaten_req", 32'(bus.query_req), 32'd0);
    chk("full_sticky", 32'(board_full), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("full_rst_clear", 32'(board_full), 32'd0);
    chk("full_rst_x", 32'(apple_x), 32'd40);
    chk("full_rst_valid", 32'(apple_valid), 32'd1);
    @(negedge pclk) rst_n = 1'b1;

    // Stalled responder: re-pulse eaten mid-query, then reset mid-query
    mode    = 0;
    resp_en = 1'b0;
    @(negedge pclk) eaten = 1'b1;
    @(negedge pclk) eaten = 1'b0;
    for (int i = 0; i < 200 && !bus.query_req; i++) @(negedge pclk);
    chk("stall_req_up", 32'(bus.query_req), 32'd1);
    hold_qx = bus.query_x;
    hold_qy = bus.query_y;
    @(negedge pclk) eaten = 1'b1;
    @(negedge pclk) eaten = 1'b0;
    repeat (3) @(negedge pclk);
    chk("stall_req_held", 32'(bus.query_req), 32'd1);
    chk("stall_qx_stable", 32'(bus.query_x), 32'(hold_qx));
    chk("stall_qy_stable", 32'(bus.query_y), 32'(hold_qy));
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_valid", 32'(apple_valid), 32'd0);
    chk("stall_keep_x", 32'(apple_x), 32'd40);
    chk("stall_keep_y", 32'(apple_y), 32'd24);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(bus.query_req), 32'd0);
    chk("abort_x", 32'(apple_x), 32'd40);
    chk("abort_y", 32'(apple_y), 32'd24);
    chk("abort_valid", 32'(apple_valid), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge pclk) rst_n = 1'b1;
    resp_en    = 1'b1;
    force_late = 1'b1;
    @(negedge pclk) force_late = 1'b0;
    repeat (3) @(negedge pclk);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_valid", 32'(apple_valid), 32'd1);
    chk("late_x", 32'(apple_x), 32'd40);
    chk("late_y", 32'(apple_y), 32'd24);
    chk("late_req", 32'(bus.query_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apple_gen.md
APPLE_GEN -- requirements
Module: apple_gen

Interface
REQ-001 SHALL have parameter GRID_COLS, default 64, meaning number of playfield columns (apple_x range 0..GRID_COLS-1).
REQ-002 SHALL have parameter GRID_ROWS, default 48, meaning number of playfield rows (apple_y range 0..GRID_ROWS-1).
REQ-003 SHALL have parameter MAX_TRIES, default 255, meaning the number of rejected random candidates before falling back to linear scan.
REQ-004 SHALL have parameters INIT_X and INIT_Y, defaults 40 and 24, meaning the apple position after reset.
REQ-005 pclk  input  1  pixel clock; the only clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 eaten  input  1  one-cycle pulse when the snake head enters the apple cell.
REQ-008 query_req  output  1  occupancy query to the snake-body store; held high until occ_valid.
REQ-009 query_x / query_y  output  7 / 6  cell being queried; stable while query_req is high.
REQ-010 occ_valid  input  1  query response strobe, 1..N cycles after query_req rises.
REQ-011 occ_hit  input  1  cell occupied by the snake; sampled only when occ_valid=1.
REQ-012 apple_x / apple_y  output  7 / 6  current apple cell, registered, fed to the apple drawing stage.
REQ-013 apple_valid  output  1  high when apple_x/apple_y hold a placed, free cell.
REQ-014 busy  output  1  high while a new position is being searched.
REQ-015 board_full  output  1  sticky; no free cell exists.

Function
REQ-016 SHALL contain a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1) advancing every pclk cycle regardless of state.
REQ-017 SHALL implement states IDLE, DRAW, QUERY, SCAN, FULL; reset state IDLE.
REQ-018 IDLE: eaten=1 -> DRAW, apple_valid<=0, busy<=1, try counter<=0; eaten=0 -> hold.
REQ-019 DRAW: candidate x=lfsr[6:0], y=lfsr[12:7]; if x>=GRID_COLS or y>=GRID_ROWS, reject, increment try counter, stay in DRAW; else load query_x/y, raise query_req, go QUERY.
REQ-020 QUERY (random origin): on occ_valid with occ_hit=0, apple_x/y<=query_x/y and apple_valid<=1 and busy<=0 on that same edge, query_req<=0, -> IDLE; with occ_hit=1, increment try counter, -> DRAW.
REQ-021 When the try counter reaches MAX_TRIES (range or occupancy rejections), SHALL enter SCAN starting at (0,0).
REQ-022 SCAN: query cells in raster order (x fastest, wrap x at GRID_COLS-1 to 0 with y+1) using the same handshake; first free cell is accepted as in REQ-020.
REQ-023 SCAN reaching (GRID_COLS-1, GRID_ROWS-1) occupied SHALL go FULL: board_full<=1, busy<=0, apple_valid stays 0.
REQ-024 FULL SHALL be left only by reset; eaten SHALL be ignored in FULL.
REQ-025 eaten during DRAW/QUERY/SCAN SHALL be ignored (no queueing).
REQ-026 query_req SHALL never drop before occ_valid; occ_valid with query_req low SHALL be ignored.
REQ-027 apple_x/apple_y SHALL retain the previous position until a new one is accepted.
REQ-028 Best-case latency eaten -> apple_valid: 1 cycle DRAW + query response latency + 1 edge.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: apple_x=INIT_X, apple_y=INIT_Y, apple_valid=1, busy=0, board_full=0, query_req=0, query_x=0, query_y=0, LFSR=0xACE1, try counter=0, state IDLE.
REQ-030 Reset mid-search SHALL abandon the query immediately; a late occ_valid after reset SHALL be ignored.

Structure
REQ-031 GRID_COLS, GRID_ROWS, LFSR seed/taps and the state encoding SHALL live in the shared snake game package/header.
REQ-032 The LFSR SHALL be a sub-module lfsr16 (pclk, rst_n, state out).
REQ-033 Coordinate widths SHALL match the drawing stage exactly (7-bit x, 6-bit y).

Verification
REQ-034 Reset release -> apple_x=40, apple_y=24, apple_valid=1, busy=0, query_req=0.
REQ-035 eaten pulse, responder always occ_hit=0 with 1-cycle latency -> apple_valid=1 within 3 cycles, x<64, y<48, query_req low after.
REQ-036 Responder returns occ_hit=1 for first 3 in-range queries -> 4th query accepted; apple equals 4th query_x/y.
REQ-037 Responder always hits except cell (5,2) -> after MAX_TRIES, SCAN from (0,0), apple=(5,2), apple_valid=1.
REQ-038 Responder always hits -> board_full=1 after scanning 3072 cells; subsequent eaten ignored; rst_n low clears board_full.
REQ-039 eaten re-pulsed during QUERY and rst_n asserted mid-QUERY -> no second search; reset restores (40,24) with query_req=0 asynchronously.
